op8_identifier: RTL
===================

// Module: op8_identifier
// PURPOSE
//  Reverse-direction companion to the 8-function two-input logic unit.
//  Drives all four (A,B) input vectors into an unknown-select logic unit and
//  samples its 1-bit result to build a 4-bit truth table. Decodes the table
//  back to the 3-bit function select that produced it.
//  Sits beside the logic unit in top-level integration for self-test and
//  select-line readback.
// PARAMETERS
//  SETTLE_CYCLES  2  cycles each vector is held before op_out is sampled (>=1);
//                    covers registered or pipelined logic-unit outputs
//  CNT_W          4  width of settle counter; must satisfy 2**CNT_W > SETTLE_CYCLES
// PORTS
//  CLK       in   1  clock, rising edge
//  RST_N     in   1  asynchronous active-low reset
//  start     in   1  request identification; accepted only in IDLE
//  abort     in   1  synchronous abort; returns to IDLE, no done pulse
//  op_out    in   1  result bit returned by the logic unit under identification
//  drive_a   out  1  A input driven to the logic unit
//  drive_b   out  1  B input driven to the logic unit
//  busy      out  1  high from the cycle after start is accepted until done
//  done      out  1  one-cycle pulse; op_sel/truth/valid/unknown are then stable
//  truth     out  4  captured table; bit {A,B} = op_out for that vector
//  op_sel    out  3  decoded function select
//  valid     out  1  truth matched one of the 8 functions
//  unknown   out  1  truth matched none; op_sel forced to 3'b000
// BEHAVIOUR
//  Reset (RST_N=0, async): state=IDLE; all outputs 0; counters 0.
//  FSM states:
//   IDLE  : drive_a/drive_b=0. start=1 at an edge -> DRIVE with idx=0, cnt=0.
//           This clears truth/valid/unknown/op_sel at the same edge.
//   DRIVE : drive_a=idx[1], drive_b=idx[0]; idx order 00,01,10,11.
//           cnt increments each cycle. At the edge where cnt==SETTLE_CYCLES-1:
//           truth[idx] <= op_out, cnt <= 0, idx <= idx+1.
//           After idx==3 is sampled -> DECODE.
//   DECODE: one cycle. Registers op_sel/valid/unknown from truth -> DONE.
//   DONE  : done=1 for exactly one cycle, busy=0 -> IDLE.
//  Decode table (truth[3:0] -> op_sel):
//   6->000 XOR, 8->001 AND, E->010 OR, 7->011 NAND, 1->100 NOR,
//   3->101 NOT A, 5->110 NOT B, 9->111 XNOR.
//   Any other value -> unknown=1, valid=0, op_sel=000.
//  Latency: done is high in cycle 4*SETTLE_CYCLES+2 after the start-accept edge.
//   With the default, this is cycle 10.
//  start while busy or in DONE: ignored, no queuing.
//  start in the same cycle as the IDLE return: accepted on the next IDLE cycle only.
//  abort has priority over all transitions. It forces IDLE, busy=0, drive_a/b=0,
//   and clears truth/valid/unknown/op_sel. No done pulse is produced.
//  Results hold unchanged in IDLE until the next accepted start.
//  Async reset mid-DRIVE: immediate return to the reset values; no partial results.
// TESTING
//  1. Logic unit select=000 (XOR), SETTLE=2, pulse start -> truth=4'h6,
//     op_sel=000, valid=1, unknown=0, done on cycle 10.
//  2. Sweep selects 001..111 -> truth 8,E,7,1,3,5,9 and op_sel equal to the
//     applied select, each with valid=1.
//  3. Tie op_out=1 -> truth=4'hF, unknown=1, valid=0, op_sel=000.
//     Tie op_out=0 -> truth=4'h0, unknown=1.
//  4. Pulse start again at cycle 4 while busy -> ignored; done occurs exactly
//     once, on cycle 10.
//  5. Assert abort during vector idx=2 -> IDLE next cycle, busy=0, no done,
//     truth=0.
//     Deassert RST_N mid-DRIVE -> all outputs 0 immediately, without a clock edge.

Source files
------------

// File: rtl/op8_identifier.sv
// Identifies which of the eight two-input logic functions a connected unit implements
// by sweeping all (A,B) vectors, capturing the 4-bit truth table and decoding it.
module op8_identifier #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       start,
  input  logic       abort,
  input  logic       op_out,
  output logic       drive_a,
  output logic       drive_b,
  output logic       busy,
  output logic       done,
  output logic [3:0] truth,
  output logic [2:0] op_sel,
  output logic       valid,
  output logic       unknown
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    DECODE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  // Returns {match, select}; a zero match bit means the table fits no function.
  function automatic logic [3:0] decode_truth(input logic [3:0] t);
    case (t)
      4'h6:    return {1'b1, 3'b000};
      4'h8:    return {1'b1, 3'b001};
      4'hE:    return {1'b1, 3'b010};
      4'h7:    return {1'b1, 3'b011};
      4'h1:    return {1'b1, 3'b100};
      4'h3:    return {1'b1, 3'b101};
      4'h5:    return {1'b1, 3'b110};
      4'h9:    return {1'b1, 3'b111};
      default: return 4'b0000;
    endcase
  endfunction

  state_t           state_r, state_s;
  logic [1:0]       idx_r, idx_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [3:0]       truth_r, truth_s;
  logic [2:0]       op_sel_r, op_sel_s;
  logic             valid_r, valid_s;
  logic             unknown_r, unknown_s;
  logic             drive_a_r, drive_a_s;
  logic             drive_b_r, drive_b_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic [3:0]       dec_s;

  assign dec_s = decode_truth(truth_r);

  // Next-state and next-output logic; every output is registered from these values.
  always_comb begin
    state_s   = state_r;
    idx_s     = idx_r;
    cnt_s     = cnt_r;
    truth_s   = truth_r;
    op_sel_s  = op_sel_r;
    valid_s   = valid_r;
    unknown_s = unknown_r;
    drive_a_s = 1'b0;
    drive_b_s = 1'b0;
    busy_s    = 1'b0;
    done_s    = 1'b0;
    if (abort) begin
      state_s   = IDLE;
      idx_s     = 2'd0;
      cnt_s     = '0;
      truth_s   = 4'h0;
      op_sel_s  = 3'b000;
      valid_s   = 1'b0;
      unknown_s = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_s   = DRIVE;
            idx_s     = 2'd0;
            cnt_s     = '0;
            truth_s   = 4'h0;
            op_sel_s  = 3'b000;
            valid_s   = 1'b0;
            unknown_s = 1'b0;
            busy_s    = 1'b1;
          end else begin
            state_s = IDLE;
          end
        end
        DRIVE: begin
          busy_s = 1'b1;
          if (cnt_r == CNT_LAST) begin
            truth_s[idx_r] = op_out;
            cnt_s          = '0;
            idx_s          = idx_r + 2'd1;
            // Present the next vector on the same edge the current one is sampled.
            if (idx_r == 2'd3) begin
              state_s = DECODE;
            end else begin
              drive_a_s = idx_s[1];
              drive_b_s = idx_s[0];
            end
          end else begin
            cnt_s     = cnt_r + CNT_W'(1);
            drive_a_s = idx_r[1];
            drive_b_s = idx_r[0];
          end
        end
        DECODE: begin
          op_sel_s  = dec_s[2:0];
          valid_s   = dec_s[3];
          unknown_s = ~dec_s[3];
          done_s    = 1'b1;
          state_s   = DONE;
        end
        DONE: begin
          state_s = IDLE;
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r   <= IDLE;
      idx_r     <= 2'd0;
      cnt_r     <= '0;
      truth_r   <= 4'h0;
      op_sel_r  <= 3'b000;
      valid_r   <= 1'b0;
      unknown_r <= 1'b0;
      drive_a_r <= 1'b0;
      drive_b_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      idx_r     <= idx_s;
      cnt_r     <= cnt_s;
      truth_r   <= truth_s;
      op_sel_r  <= op_sel_s;
      valid_r   <= valid_s;
      unknown_r <= unknown_s;
      drive_a_r <= drive_a_s;
      drive_b_r <= drive_b_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
    end
  end

  assign drive_a = drive_a_r;
  assign drive_b = drive_b_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign truth   = truth_r;
  assign op_sel  = op_sel_r;
  assign valid   = valid_r;
  assign unknown = unknown_r;

endmodule
